// File: rtl/lc3b_types.sv
// Shared lc3b types: opcodes, decode ROM control word, register index and issue FSM states.
// No logic; imported by the issue stage and its counter bank.
// Control word field order matches the decode ROM output bus.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  localparam lc3b_reg R7 = 3'd7;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    alu_add  = 2'b00,
    alu_and  = 2'b01,
    alu_not  = 2'b10,
    alu_pass = 2'b11
  } lc3b_aluop;

  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_aluop  aluop;
    logic       uses_sr1;
    logic       instrsr1_mux_sel;
    logic       uses_sr2;
    logic       sr2_mux_sel;
    logic       load_regfile;
    logic       dest_mux_sel;
    logic       load_cc;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
  } lc3b_control;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } issue_state_t;

  // Branch instructions are the only consumers of the condition codes.
  function automatic logic reads_cc(input lc3b_control c);
    return c.opcode == op_br;
  endfunction

endpackage

// File: rtl/pending_counter_bank.sv
// Bank of N saturating-free pending-writer counters, one increment and one decrement port.
// Counters update one cycle after inc/dec; status vectors are straight from the registers.
// No backpressure: the owner must never increment a counter that reports at_max.
module pending_counter_bank
  import lc3b_types::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic [IDX_W-1:0] inc_idx_i,
  input  logic             dec_i,
  input  logic [IDX_W-1:0] dec_idx_i,
  output logic [N-1:0]     nonzero_o,
  output logic [N-1:0]     at_max_o
);

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     inc_hit;
  logic [N-1:0]     dec_hit;

  // Decode the ports per entry; a decrement of an empty counter is dropped.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inc_hit[i] = inc_i && (inc_idx_i == IDX_W'(i));
      dec_hit[i] = dec_i && (dec_idx_i == IDX_W'(i)) && (cnt_q[i] != '0);
    end
  end

  // Next count: increment and decrement of the same entry cancel out.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_hit[i] && !dec_hit[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!inc_hit[i] && dec_hit[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Counter registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // A retirement must always match an earlier issue; an empty counter means lost tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        assert (!(dec_i && (dec_idx_i == IDX_W'(i)) && (cnt_q[i] == '0)));
      end
    end
  end

  // Status vectors feeding the hazard compare.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      nonzero_o[i] = (cnt_q[i] != '0);
      at_max_o[i]  = (cnt_q[i] == {CNT_W{1'b1}});
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-to-EX issue stage: RAW/CC hazard check, issue register, branch hold FSM.
// Latency: accepted decode word appears in the issue register the next cycle.
// Backpressure: dec_ready drops on hazard, full issue register without ex_ready, or branch wait.
module issue_scoreboard
  import lc3b_types::*;
#(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  lc3b_control dec_ctrl,
  input  logic [2:0]  dec_sr1,
  input  logic [2:0]  dec_sr2,
  input  logic [2:0]  dec_dest,
  output logic        dec_ready,
  output logic        issue_valid,
  output lc3b_control issue_ctrl,
  output logic [2:0]  issue_dest,
  input  logic        ex_ready,
  input  logic        wb_valid,
  input  logic        wb_load_regfile,
  input  logic [2:0]  wb_dest,
  input  logic        wb_load_cc,
  input  logic        branch_resolved,
  output logic        fetch_hold
);

  issue_state_t state_q, state_d;

  logic        issue_valid_q;
  lc3b_control issue_ctrl_q;
  lc3b_reg     issue_dest_q;

  logic [7:0]  reg_busy;
  logic [7:0]  reg_full;
  logic [0:0]  cc_busy;
  logic [0:0]  cc_full;

  logic        rd1, rd2, readcc, writer, hazard, out_free;
  lc3b_reg     dest_eff;

  assign rd1      = dec_ctrl.uses_sr1 | dec_ctrl.instrsr1_mux_sel;
  assign rd2      = dec_ctrl.uses_sr2 | dec_ctrl.sr2_mux_sel;
  assign readcc   = reads_cc(dec_ctrl);
  assign writer   = dec_ctrl.load_regfile;
  assign dest_eff = dec_ctrl.dest_mux_sel ? R7 : dec_dest;

  // Retirements only affect the counters at the clock edge, so a WB in cycle N unblocks N+1.
  assign hazard = (rd1 & reg_busy[dec_sr1])
                | (rd2 & reg_busy[dec_sr2])
                | (readcc & cc_busy[0])
                | (writer & reg_full[dest_eff])
                | (dec_ctrl.load_cc & cc_full[0]);

  assign out_free = ~issue_valid_q | ex_ready;

  pending_counter_bank #(
    .N     (8),
    .CNT_W (CNT_W)
  ) u_reg_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (dec_ready & writer),
    .inc_idx_i (dest_eff),
    .dec_i     (wb_valid & wb_load_regfile),
    .dec_idx_i (wb_dest),
    .nonzero_o (reg_busy),
    .at_max_o  (reg_full)
  );

  pending_counter_bank #(
    .N     (1),
    .CNT_W (CNT_W)
  ) u_cc_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (dec_ready & dec_ctrl.load_cc),
    .inc_idx_i (1'b0),
    .dec_i     (wb_valid & wb_load_cc),
    .dec_idx_i (1'b0),
    .nonzero_o (cc_busy),
    .at_max_o  (cc_full)
  );

  // Branch FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Accept/hold decisions and branch FSM transitions.
  always_comb begin
    state_d    = state_q;
    dec_ready  = 1'b0;
    fetch_hold = 1'b0;
    case (state_q)
      RUN: begin
        dec_ready  = dec_valid & out_free & ~hazard;
        fetch_hold = dec_valid & ~dec_ready;
        if (dec_ready && dec_ctrl.branch) begin
          state_d = BR_WAIT;
        end
      end
      BR_WAIT: begin
        fetch_hold = 1'b1;
        if (branch_resolved) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Issue register: load on accept, drain when EX takes it with nothing new behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid_q <= 1'b0;
      issue_ctrl_q  <= '0;
      issue_dest_q  <= '0;
    end else if (dec_ready) begin
      issue_valid_q <= 1'b1;
      issue_ctrl_q  <= dec_ctrl;
      issue_dest_q  <= dest_eff;
    end else if (ex_ready) begin
      issue_valid_q <= 1'b0;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_ctrl  = issue_ctrl_q;
  assign issue_dest  = issue_dest_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: per-cycle dec_ready/fetch_hold checks plus an
// issue-register scoreboard (push on expected accept, pop when EX takes the issue register).
module tb_issue_scoreboard;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  lc3b_control dec_ctrl;
  logic [2:0]  dec_sr1, dec_sr2, dec_dest;
  logic        dec_ready;
  logic        issue_valid;
  lc3b_control issue_ctrl;
  logic [2:0]  issue_dest;
  logic        ex_ready;
  logic        wb_valid, wb_load_regfile, wb_load_cc;
  logic [2:0]  wb_dest;
  logic        branch_resolved;
  logic        fetch_hold;

  typedef struct packed {
    lc3b_control ctrl;
    logic [2:0]  dest;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.CNT_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .dec_valid       (dec_valid),
    .dec_ctrl        (dec_ctrl),
    .dec_sr1         (dec_sr1),
    .dec_sr2         (dec_sr2),
    .dec_dest        (dec_dest),
    .dec_ready       (dec_ready),
    .issue_valid     (issue_valid),
    .issue_ctrl      (issue_ctrl),
    .issue_dest      (issue_dest),
    .ex_ready        (ex_ready),
    .wb_valid        (wb_valid),
    .wb_load_regfile (wb_load_regfile),
    .wb_dest         (wb_dest),
    .wb_load_cc      (wb_load_cc),
    .branch_resolved (branch_resolved),
    .fetch_hold      (fetch_hold)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // EX takes the issue register on this edge: compare against the oldest accepted word.
  always @(negedge clk) begin
    if (issue_valid === 1'b1 && ex_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_depth", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_ctrl", 32'(issue_ctrl), 32'(e.ctrl));
        chk("sb_dest", 32'(issue_dest), 32'(e.dest));
      end
    end
  end

  function automatic lc3b_control mk_alu(input lc3b_opcode op);
    lc3b_control c;
    c              = '0;
    c.opcode       = op;
    c.aluop        = (op == op_and) ? alu_and : alu_add;
    c.uses_sr1     = 1'b1;
    c.uses_sr2     = 1'b1;
    c.load_regfile = 1'b1;
    c.load_cc      = 1'b1;
    return c;
  endfunction

  function automatic lc3b_control mk_br();
    lc3b_control c;
    c        = '0;
    c.opcode = op_br;
    c.branch = 1'b1;
    return c;
  endfunction

  function automatic lc3b_control mk_jsr();
    lc3b_control c;
    c              = '0;
    c.opcode       = op_jsr;
    c.load_regfile = 1'b1;
    c.dest_mux_sel = 1'b1;
    c.branch       = 1'b1;
    return c;
  endfunction

  task automatic dec(input lc3b_control c, input logic [2:0] s1, input logic [2:0] s2,
                     input logic [2:0] d);
    dec_valid = 1'b1;
    dec_ctrl  = c;
    dec_sr1   = s1;
    dec_sr2   = s2;
    dec_dest  = d;
  endtask

  task automatic idle();
    dec_valid = 1'b0;
    dec_ctrl  = '0;
    dec_sr1   = '0;
    dec_sr2   = '0;
    dec_dest  = '0;
  endtask

  task automatic wb(input logic [2:0] d, input logic lr, input logic lcc);
    wb_valid        = 1'b1;
    wb_dest         = d;
    wb_load_regfile = lr;
    wb_load_cc      = lcc;
  endtask

  // Sample away from the edge; record expected issue contents on an expected accept.
  task automatic smp(input string tag, input logic exp_rdy, input logic exp_hold,
                     input logic [2:0] exp_dest);
    exp_t e;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(dec_ready), 32'(exp_rdy));
    chk({tag, "_hold"}, 32'(fetch_hold), 32'(exp_hold));
    if (exp_rdy) begin
      e.ctrl = dec_ctrl;
      e.dest = exp_dest;
      sb_q.push_back(e);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    wb_valid        = 1'b0;
    wb_load_regfile = 1'b0;
    wb_load_cc      = 1'b0;
    wb_dest         = '0;
    branch_resolved = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic exp_rdy, input logic exp_hold,
                     input logic [2:0] exp_dest);
    smp(tag, exp_rdy, exp_hold, exp_dest);
    adv();
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    ex_ready = 1'b1;
    idle();
    adv();
    adv();
    reset = 1'b0;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    reset           = 1'b1;
    ex_ready        = 1'b1;
    wb_valid        = 1'b0;
    wb_load_regfile = 1'b0;
    wb_load_cc      = 1'b0;
    wb_dest         = '0;
    branch_resolved = 1'b0;
    idle();
    #1;
    reset_dut();

    // Reset state.
    @(negedge clk);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_ctrl", 32'(issue_ctrl), 32'd0);
    chk("rst_issue_dest", 32'(issue_dest), 32'd0);
    chk("rst_fetch_hold", 32'(fetch_hold), 32'd0);
    chk("rst_dec_ready", 32'(dec_ready), 32'd0);
    adv();

    // 1: RAW on R1, retired at cycle 4, dependent issues at cycle 5.
    reset_dut();
    dec(mk_alu(op_add), 3'd2, 3'd3, 3'd1);
    cyc("t1_first", 1'b1, 1'b0, 3'd1);
    dec(mk_alu(op_add), 3'd1, 3'd5, 3'd4);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) wb(3'd1, 1'b1, 1'b1);
      cyc("t1_stall", 1'b0, 1'b1, 3'd0);
    end
    cyc("t1_dep", 1'b1, 1'b0, 3'd4);
    idle();
    cyc("t1_idle", 1'b0, 1'b0, 3'd0);

    // 2: three writers to R2 fill the counter; the fourth waits for an R2 retirement.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      dec(mk_alu(op_add), 3'd0, 3'd1, 3'd2);
      cyc("t2_fill", 1'b1, 1'b0, 3'd2);
    end
    dec(mk_alu(op_add), 3'd0, 3'd1, 3'd2);
    wb(3'd0, 1'b0, 1'b1);
    cyc("t2_full_cc", 1'b0, 1'b1, 3'd0);
    wb(3'd2, 1'b1, 1'b0);
    cyc("t2_full_r2", 1'b0, 1'b1, 3'd0);
    cyc("t2_fourth", 1'b1, 1'b0, 3'd2);
    idle();
    cyc("t2_idle", 1'b0, 1'b0, 3'd0);

    // 3: BR waits for CC, then holds fetch until branch_resolved.
    reset_dut();
    dec(mk_alu(op_and), 3'd2, 3'd3, 3'd1);
    cyc("t3_and", 1'b1, 1'b0, 3'd1);
    dec(mk_br(), 3'd0, 3'd0, 3'd0);
    cyc("t3_br_cc", 1'b0, 1'b1, 3'd0);
    wb(3'd1, 1'b1, 1'b1);
    cyc("t3_br_cc_wb", 1'b0, 1'b1, 3'd0);
    cyc("t3_br", 1'b1, 1'b0, 3'd0);
    dec(mk_alu(op_add), 3'd6, 3'd6, 3'd5);
    cyc("t3_wait", 1'b0, 1'b1, 3'd0);
    branch_resolved = 1'b1;
    cyc("t3_resolve", 1'b0, 1'b1, 3'd0);
    cyc("t3_run", 1'b1, 1'b0, 3'd5);
    idle();
    branch_resolved = 1'b1;
    cyc("t3_stray_res", 1'b0, 1'b0, 3'd0);
    cyc("t3_after", 1'b0, 1'b0, 3'd0);

    // 4: JSR writes R7 regardless of IR[11:9]; reader of R7 waits for its retirement.
    reset_dut();
    dec(mk_jsr(), 3'd0, 3'd0, 3'd3);
    cyc("t4_jsr", 1'b1, 1'b0, 3'd7);
    dec(mk_alu(op_add), 3'd7, 3'd0, 3'd0);
    branch_resolved = 1'b1;
    smp("t4_brwait", 1'b0, 1'b1, 3'd0);
    chk("t4_issue_dest", 32'(issue_dest), 32'd7);
    adv();
    cyc("t4_r7_busy", 1'b0, 1'b1, 3'd0);
    wb(3'd7, 1'b1, 1'b0);
    cyc("t4_r7_wb", 1'b0, 1'b1, 3'd0);
    cyc("t4_add", 1'b1, 1'b0, 3'd0);
    idle();
    cyc("t4_idle", 1'b0, 1'b0, 3'd0);

    // 5: EX backpressure holds the issue register; release gives back-to-back issue.
    reset_dut();
    ex_ready = 1'b0;
    dec(mk_alu(op_add), 3'd2, 3'd3, 3'd1);
    cyc("t5_add", 1'b1, 1'b0, 3'd1);
    dec(mk_alu(op_and), 3'd5, 3'd6, 3'd4);
    for (int i = 0; i < 3; i++) begin
      smp("t5_bp", 1'b0, 1'b1, 3'd0);
      chk("t5_issue_valid", 32'(issue_valid), 32'd1);
      chk("t5_issue_ctrl", 32'(issue_ctrl), 32'(mk_alu(op_add)));
      adv();
    end
    ex_ready = 1'b1;
    cyc("t5_and", 1'b1, 1'b0, 3'd4);
    dec(mk_alu(op_add), 3'd0, 3'd0, 3'd7);
    cyc("t5_b2b", 1'b1, 1'b0, 3'd7);
    idle();
    cyc("t5_idle", 1'b0, 1'b0, 3'd0);

    // 6: same-cycle issue and retire of R3 keeps the count, then reset mid-stall.
    reset_dut();
    dec(mk_alu(op_add), 3'd0, 3'd1, 3'd3);
    cyc("t6_w1", 1'b1, 1'b0, 3'd3);
    dec(mk_alu(op_add), 3'd0, 3'd1, 3'd3);
    wb(3'd3, 1'b1, 1'b0);
    cyc("t6_w2_wb", 1'b1, 1'b0, 3'd3);
    dec(mk_alu(op_add), 3'd3, 3'd0, 3'd4);
    wb(3'd3, 1'b1, 1'b0);
    cyc("t6_cnt1", 1'b0, 1'b1, 3'd0);
    cyc("t6_cnt0", 1'b1, 1'b0, 3'd4);
    dec(mk_alu(op_add), 3'd4, 3'd0, 3'd5);
    reset = 1'b1;
    cyc("t6_stall", 1'b0, 1'b1, 3'd0);
    reset = 1'b0;
    idle();
    smp("t6_post_rst", 1'b0, 1'b0, 3'd0);
    chk("t6_issue_valid", 32'(issue_valid), 32'd0);
    chk("t6_issue_ctrl", 32'(issue_ctrl), 32'd0);
    chk("t6_issue_dest", 32'(issue_dest), 32'd0);
    adv();
    dec(mk_alu(op_add), 3'd4, 3'd0, 3'd5);
    cyc("t6_cleared", 1'b1, 1'b0, 3'd5);
    idle();
    cyc("t6_idle", 1'b0, 1'b0, 3'd0);
    cyc("t6_idle2", 1'b0, 1'b0, 3'd0);

    chk("sb_final", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
